// File: rtl/out_packer_pkg.sv
// Shared types and helpers for the bit-to-word packer and its holding register.
package out_packer_pkg;

    // Default number of bits per packed word.
    localparam int DEFAULT_WORD_W = 8;

    // FILL: normal accumulation. FLUSH_WAIT: a partial word waits for the hold register.
    typedef enum logic {
        FILL       = 1'b0,
        FLUSH_WAIT = 1'b1
    } state_t;

    // Observability bundle so checkers can see the control state directly.
    typedef struct packed {
        state_t state;
        logic   flush_pend;
    } dbg_t;

    // Width of a counter that must hold 0..word_w inclusive.
    function automatic int count_w(input int word_w);
        return $clog2(word_w + 1);
    endfunction

endpackage

// File: rtl/word_hold_reg.sv
// One-deep valid/ready output holding register for packed words.
// Handshake: a word is transferred on any cycle where valid && ready; valid,
// data and count stay stable until then. A load in the same cycle as a
// transfer replaces the departing word, so the register can stream at full rate.
module word_hold_reg #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CNT_W-1:0]  load_count,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CNT_W-1:0]  count,
    output logic              free
);

    // The register can accept a new word when it is empty or being drained now.
    assign free = !valid || ready;

    // Capture a new word on load, otherwise drop valid once the consumer takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            count <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            count <= load_count;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/out_packer.sv
// Packs a stream of single bits into WORD_W-bit words with an explicit flush.
// Handshake: bits transfer on bit_valid && bit_ready; words transfer on
// word_valid && word_ready. Words hold stable until taken.
module out_packer
    import out_packer_pkg::*;
#(
    parameter  int WORD_W    = DEFAULT_WORD_W,
    parameter  int MSB_FIRST = 0,
    localparam int CW        = count_w(WORD_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic              bit_ready,
    input  logic              flush,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_data,
    output logic [CW-1:0]     word_count,
    input  logic              word_ready,
    output dbg_t              dbg
);

    localparam logic [CW-1:0] LAST_IDX = CW'(WORD_W - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(WORD_W);

    state_t            state;
    logic              flush_pend;
    logic [CW-1:0]     fill_cnt;
    logic [WORD_W-1:0] acc;

    logic              hold_free;
    logic              accept;
    int                pos;
    logic [CW-1:0]     cnt_with;
    logic [WORD_W-1:0] acc_with;
    logic              load;
    logic              clear_acc;
    logic              enter_wait;

    // A word-completing bit is only taken when the hold register can absorb it.
    assign bit_ready = !reset && (state == FILL) && ((fill_cnt < LAST_IDX) || hold_free);
    assign accept    = bit_valid && bit_ready;

    assign dbg.state      = state;
    assign dbg.flush_pend = flush_pend;

    // Merge the accepted bit, then decide whether a full or partial word leaves.
    always_comb begin
        pos        = (MSB_FIRST != 0) ? (WORD_W - 1 - int'(fill_cnt)) : int'(fill_cnt);
        acc_with   = acc;
        if (accept) begin
            for (int i = 0; i < WORD_W; i++) begin
                if (i == pos) acc_with[i] = bit_in;
            end
        end
        cnt_with   = fill_cnt + CW'(accept);
        load       = 1'b0;
        clear_acc  = 1'b0;
        enter_wait = 1'b0;
        if (state == FLUSH_WAIT) begin
            // No bits are accepted here, so acc_with is the pending partial word.
            if (word_ready) begin
                load      = 1'b1;
                clear_acc = 1'b1;
            end
        end else if (cnt_with == FULL_CNT) begin
            // Full word; any simultaneous flush is absorbed since nothing remains.
            load      = 1'b1;
            clear_acc = 1'b1;
        end else if (flush && (cnt_with != '0)) begin
            if (hold_free) begin
                load      = 1'b1;
                clear_acc = 1'b1;
            end else begin
                enter_wait = 1'b1;
            end
        end
    end

    // Accumulator, fill counter and flush-wait state machine.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FILL;
            flush_pend <= 1'b0;
            fill_cnt   <= '0;
            acc        <= '0;
        end else begin
            if (clear_acc) begin
                fill_cnt <= '0;
                acc      <= '0;
            end else begin
                fill_cnt <= cnt_with;
                acc      <= acc_with;
            end
            if (enter_wait) begin
                state      <= FLUSH_WAIT;
                flush_pend <= 1'b1;
            end else if ((state == FLUSH_WAIT) && load) begin
                state      <= FILL;
                flush_pend <= 1'b0;
            end
        end
    end

    word_hold_reg #(
        .DATA_W (WORD_W),
        .CNT_W  (CW)
    ) u_hold (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_data  (acc_with),
        .load_count (cnt_with),
        .ready      (word_ready),
        .valid      (word_valid),
        .data       (word_data),
        .count      (word_count),
        .free       (hold_free)
    );

endmodule

// File: tb/tb_out_packer.sv
// Directed bench for out_packer with WORD_W=8, LSB-first and MSB-first instances.
module tb_out_packer;
    import out_packer_pkg::*;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          bit_valid;
    logic          bit_in;
    logic          flush;
    logic          word_ready;

    logic          l_bit_ready;
    logic          l_word_valid;
    logic [W-1:0]  l_word_data;
    logic [CW-1:0] l_word_count;
    dbg_t          l_dbg;

    logic          m_bit_ready;
    logic          m_word_valid;
    logic [W-1:0]  m_word_data;
    logic [CW-1:0] m_word_count;
    dbg_t          m_dbg;

    int            total = 0;
    int            bad   = 0;
    logic [11:0]   exp_q[$];

    // Clock
    always #5 clk = ~clk;

    out_packer #(.WORD_W(W), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in),
        .bit_ready(l_bit_ready), .flush(flush), .word_valid(l_word_valid),
        .word_data(l_word_data), .word_count(l_word_count),
        .word_ready(word_ready), .dbg(l_dbg)
    );

    out_packer #(.WORD_W(W), .MSB_FIRST(1)) u_msb (
        .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in),
        .bit_ready(m_bit_ready), .flush(flush), .word_valid(m_word_valid),
        .word_data(m_word_data), .word_count(m_word_count),
        .word_ready(word_ready), .dbg(m_dbg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Offer one bit that must be accepted this cycle.
    task automatic send_bit(input logic b, input string tag);
        bit_valid = 1'b1;
        bit_in    = b;
        #1;
        check({tag, "_rdy"}, l_bit_ready, 1);
        cycle();
        bit_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n, input string tag);
        for (int i = 0; i < n; i++) send_bit(v[i], tag);
    endtask

    // Compare the held LSB-first word against the next expected {count,data}.
    task automatic check_word(input string tag);
        logic [11:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_qempty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, l_word_valid, 1);
            check({tag, "_data"}, l_word_data, e[7:0]);
            check({tag, "_count"}, l_word_count, e[11:8]);
        end
    endtask

    initial begin
        logic [7:0] w2;
        // Reset
        reset = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; flush = 1'b0; word_ready = 1'b0;
        cycle(); cycle();
        check("rst_valid", l_word_valid, 0);
        check("rst_data", l_word_data, 0);
        check("rst_count", l_word_count, 0);
        check("rst_bit_ready", l_bit_ready, 0);
        check("rst_state", l_dbg.state, FILL);
        check("rst_pend", l_dbg.flush_pend, 0);
        reset = 1'b0;
        #1;
        check("post_rst_rdy", l_bit_ready, 1);

        // Full word, both bit orders
        word_ready = 1'b1;
        send_bits(8'h8D, 8, "t1");
        exp_q.push_back({4'd8, 8'h8D});
        check_word("t1");
        check("t1_msb_data", m_word_data, 8'hB1);
        check("t1_msb_count", m_word_count, 8);
        cycle();
        check("t1_drained", l_word_valid, 0);

        // Back-pressure: 16 bits with word_ready low
        word_ready = 1'b0;
        send_bits(8'hA5, 8, "t3a");
        exp_q.push_back({4'd8, 8'hA5});
        check_word("t3_w1");
        w2 = 8'h3C;
        send_bits(w2, 7, "t3b");
        for (int k = 0; k < 3; k++) begin
            bit_valid = 1'b1;
            bit_in    = w2[7];
            #1;
            check("t3_bit16_blocked", l_bit_ready, 0);
            cycle();
            check("t3_hold_valid", l_word_valid, 1);
            check("t3_hold_data", l_word_data, 8'hA5);
        end
        word_ready = 1'b1;
        #1;
        check("t3_bit16_rdy", l_bit_ready, 1);
        cycle();
        bit_valid  = 1'b0;
        word_ready = 1'b0;
        exp_q.push_back({4'd8, 8'h3C});
        check_word("t3_w2");
        word_ready = 1'b1;
        cycle();
        check("t3_drained", l_word_valid, 0);

        // Flush with a free register, empty flush, and flush absorbed by a full word
        send_bits(8'b0000_0011, 3, "t4");
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        exp_q.push_back({4'd3, 8'h03});
        check_word("t4_part");
        check("t4_msb_data", m_word_data, 8'hC0);
        cycle();
        check("t4_drained", l_word_valid, 0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("t4_empty_flush", l_word_valid, 0);
        send_bits(8'h0F, 8, "t4b");
        exp_q.push_back({4'd8, 8'h0F});
        check_word("t4_next");
        send_bits(8'hFE, 7, "t4c");
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        flush     = 1'b1;
        cycle();
        bit_valid = 1'b0;
        flush     = 1'b0;
        exp_q.push_back({4'd8, 8'hFE});
        check_word("t4_absorb");
        cycle();
        check("t4_absorb_none", l_word_valid, 0);
        check("t4_absorb_state", l_dbg.state, FILL);

        // Flush while the hold register is full
        word_ready = 1'b0;
        send_bits(8'h55, 8, "t5a");
        exp_q.push_back({4'd8, 8'h55});
        check_word("t5_w1");
        send_bits(8'b0000_0001, 2, "t5b");
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("t5_state_wait", l_dbg.state, FLUSH_WAIT);
        check("t5_pend", l_dbg.flush_pend, 1);
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        #1;
        check("t5_rdy_low", l_bit_ready, 0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        bit_valid = 1'b0;
        check("t5_still_wait", l_dbg.state, FLUSH_WAIT);
        check("t5_hold_data", l_word_data, 8'h55);
        word_ready = 1'b1;
        cycle();
        word_ready = 1'b0;
        exp_q.push_back({4'd2, 8'h01});
        check_word("t5_part");
        check("t5_msb_data", m_word_data, 8'h80);
        check("t5_msb_count", m_word_count, 2);
        check("t5_state_fill", l_dbg.state, FILL);
        check("t5_pend_clr", l_dbg.flush_pend, 0);
        #1;
        check("t5_rdy_back", l_bit_ready, 1);
        word_ready = 1'b1;
        cycle();
        check("t5_drained", l_word_valid, 0);

        // Reset mid-word discards the partial fill
        send_bits(8'h1F, 5, "t6a");
        reset = 1'b1;
        cycle();
        check("t6_rst_valid", l_word_valid, 0);
        check("t6_rst_rdy", l_bit_ready, 0);
        reset = 1'b0;
        cycle();
        check("t6_no_partial", l_word_valid, 0);
        send_bits(8'hFF, 8, "t6b");
        exp_q.push_back({4'd8, 8'hFF});
        check_word("t6_word");
        cycle();

        check("exp_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
